pio_cmd_bridge: RTL and testbench

- Converts the Nios II system's four 32-bit PIO output words into single-outstanding commands on an accelerator valid/ready request port.
- Returns result, status and latency on the system's four 32-bit PIO input words.
- Sits directly between `system1` and the accelerator core.
- PIOs have no strobes, so the handshake uses a toggle bit: software flips req, and the bridge flips ack on completion.

---
 rtl/pio_bridge_pkg.sv | 27 ++
 rtl/pio_bridge_timer.sv | 37 +++
 rtl/pio_cmd_bridge.sv | 168 ++++++++++++++++
 tb/tb_pio_cmd_bridge.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pio_bridge_pkg.sv
// Shared types and PIO word layout for the Nios PIO to accelerator command bridge.
package pio_bridge_pkg;

  localparam int PIO_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_RSP,
    ST_DONE
  } bridge_state_e;

  // Status word (pio_in1) bit positions
  localparam int STAT_ACK    = 0;
  localparam int STAT_BUSY   = 1;
  localparam int STAT_ERR    = 2;
  localparam int STAT_TMO    = 3;
  localparam int LAST_OP_LSB = 8;
  localparam int COUNT_LSB   = 16;

  // Command word field positions
  localparam int OP_LSB   = 0;
  localparam int ADDR_LSB = 8;
  localparam int REQ_BIT  = 0;
  localparam int CLR_BIT  = 31;

endpackage

// File: rtl/pio_bridge_timer.sv
// Saturating per-command cycle counter with timeout limit selection and compare.
module pio_bridge_timer
  import pio_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             start,
  input  logic             run,
  input  logic [15:0]      limit,
  output logic [PIO_W-1:0] elapsed,
  output logic             expired
);

  localparam logic [PIO_W-1:0] DEF_LIMIT = TIMEOUT_CYCLES;

  logic [PIO_W-1:0] limit_sel;

  assign limit_sel = (limit != '0) ? {16'h0000, limit} : DEF_LIMIT;
  // Greater-or-equal keeps a limit lowered mid-command from being skipped past
  assign expired   = (elapsed >= limit_sel);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      elapsed <= '0;
    end else if (clr) begin
      elapsed <= '0;
    end else if (start) begin
      elapsed <= 32'd1;
    end else if (run && (elapsed != '1)) begin
      elapsed <= elapsed + 32'd1;
    end
  end

endmodule

// File: rtl/pio_cmd_bridge.sv
// Toggle-handshake bridge: turns PIO output words into one-outstanding accelerator
// requests and reports result, status and latency back on the PIO input words.
module pio_cmd_bridge
  import pio_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter logic [31:0] VERSION        = 32'h0001_0000
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [PIO_W-1:0]  pio_out0,
  input  logic [PIO_W-1:0]  pio_out1,
  input  logic [PIO_W-1:0]  pio_out2,
  input  logic [PIO_W-1:0]  pio_out3,
  output logic [PIO_W-1:0]  pio_in0,
  output logic [PIO_W-1:0]  pio_in1,
  output logic [PIO_W-1:0]  pio_in2,
  output logic [PIO_W-1:0]  pio_in3,
  output logic              acc_req_valid,
  input  logic              acc_req_ready,
  output logic [7:0]        acc_req_op,
  output logic [ADDR_W-1:0] acc_req_addr,
  output logic [PIO_W-1:0]  acc_req_data,
  input  logic              acc_rsp_valid,
  input  logic [PIO_W-1:0]  acc_rsp_data,
  input  logic              acc_rsp_err
);

  bridge_state_e    state;
  logic             ack, busy, err, tmo;
  logic [15:0]      count;
  logic [7:0]       last_op;
  logic [PIO_W-1:0] result, last_elapsed;
  logic [PIO_W-1:0] rsp_data_q;
  logic             rsp_err_q, tmo_q;

  logic             soft_clr, req_pending, rsp_done, tmo_evt;
  logic             tmr_start, tmr_run, expired;
  logic [PIO_W-1:0] elapsed;
  logic             unused_bits;

  assign soft_clr    = pio_out2[CLR_BIT];
  assign req_pending = (pio_out2[REQ_BIT] != ack);
  assign unused_bits = ^{pio_out0[PIO_W-1:ADDR_LSB+ADDR_W], pio_out2[CLR_BIT-1:REQ_BIT+1],
                         pio_out3[PIO_W-1:16]};

  // A response arriving in the limit cycle completes normally instead of timing out
  always_comb begin
    rsp_done = 1'b0;
    tmo_evt  = 1'b0;
    unique case (state)
      ST_ISSUE: begin
        rsp_done = acc_req_ready && acc_rsp_valid;
        tmo_evt  = !rsp_done && expired;
      end
      ST_WAIT_RSP: begin
        rsp_done = acc_rsp_valid;
        tmo_evt  = !rsp_done && expired;
      end
      default: ;
    endcase
  end

  assign tmr_start = (state == ST_IDLE) && req_pending && !soft_clr;
  assign tmr_run   = ((state == ST_ISSUE) || (state == ST_WAIT_RSP)) &&
                     !rsp_done && !tmo_evt && !soft_clr;

  pio_bridge_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk_clk),
    .rst_n   (reset_reset_n),
    .clr     (soft_clr),
    .start   (tmr_start),
    .run     (tmr_run),
    .limit   (pio_out3[15:0]),
    .elapsed (elapsed),
    .expired (expired)
  );

  // Completion data is staged so result, status and latency all appear at the DONE edge
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state         <= ST_IDLE;
      ack           <= 1'b0;
      busy          <= 1'b0;
      err           <= 1'b0;
      tmo           <= 1'b0;
      count         <= '0;
      last_op       <= '0;
      result        <= '0;
      last_elapsed  <= '0;
      rsp_data_q    <= '0;
      rsp_err_q     <= 1'b0;
      tmo_q         <= 1'b0;
      acc_req_valid <= 1'b0;
      acc_req_op    <= '0;
      acc_req_addr  <= '0;
      acc_req_data  <= '0;
    end else if (soft_clr) begin
      state         <= ST_IDLE;
      ack           <= pio_out2[REQ_BIT];
      busy          <= 1'b0;
      err           <= 1'b0;
      tmo           <= 1'b0;
      count         <= '0;
      result        <= '0;
      last_elapsed  <= '0;
      rsp_data_q    <= '0;
      rsp_err_q     <= 1'b0;
      tmo_q         <= 1'b0;
      acc_req_valid <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (req_pending) begin
            acc_req_op    <= pio_out0[OP_LSB +: 8];
            acc_req_addr  <= pio_out0[ADDR_LSB +: ADDR_W];
            acc_req_data  <= pio_out1;
            acc_req_valid <= 1'b1;
            busy          <= 1'b1;
            state         <= ST_ISSUE;
          end
        end
        ST_ISSUE, ST_WAIT_RSP: begin
          if (rsp_done || tmo_evt) begin
            acc_req_valid <= 1'b0;
            rsp_data_q    <= rsp_done ? acc_rsp_data : '0;
            rsp_err_q     <= rsp_done && acc_rsp_err;
            tmo_q         <= tmo_evt;
            state         <= ST_DONE;
          end else if ((state == ST_ISSUE) && acc_req_ready) begin
            acc_req_valid <= 1'b0;
            state         <= ST_WAIT_RSP;
          end
        end
        ST_DONE: begin
          ack          <= ~ack;
          busy         <= 1'b0;
          count        <= count + 16'd1;
          last_op      <= acc_req_op;
          last_elapsed <= elapsed;
          result       <= rsp_data_q;
          err          <= rsp_err_q;
          tmo          <= tmo_q;
          state        <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    pio_in1                      = '0;
    pio_in1[STAT_ACK]            = ack;
    pio_in1[STAT_BUSY]           = busy;
    pio_in1[STAT_ERR]            = err;
    pio_in1[STAT_TMO]            = tmo;
    pio_in1[LAST_OP_LSB +: 8]    = last_op;
    pio_in1[COUNT_LSB +: 16]     = count;
  end

  assign pio_in0 = result;
  assign pio_in2 = last_elapsed;
  assign pio_in3 = VERSION;

endmodule

// File: tb/tb_pio_cmd_bridge.sv
// Randomized bench for pio_cmd_bridge with a per-command latency/result model.
`timescale 1ns/1ps
module tb_pio_cmd_bridge;

  localparam int ADDR_W = 8;
  localparam logic [31:0] VERSION = 32'h0001_0000;
  localparam int NEVER = 1000;

  logic              clk_clk = 1'b0;
  logic              reset_reset_n;
  logic [31:0]       pio_out0, pio_out1, pio_out2, pio_out3;
  logic [31:0]       pio_in0, pio_in1, pio_in2, pio_in3;
  logic              acc_req_valid, acc_req_ready;
  logic [7:0]        acc_req_op;
  logic [ADDR_W-1:0] acc_req_addr;
  logic [31:0]       acc_req_data;
  logic              acc_rsp_valid, acc_rsp_err;
  logic [31:0]       acc_rsp_data;

  pio_cmd_bridge #(
    .ADDR_W(ADDR_W), .TIMEOUT_CYCLES(65535), .VERSION(VERSION)
  ) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .pio_out0(pio_out0), .pio_out1(pio_out1), .pio_out2(pio_out2), .pio_out3(pio_out3),
    .pio_in0(pio_in0), .pio_in1(pio_in1), .pio_in2(pio_in2), .pio_in3(pio_in3),
    .acc_req_valid(acc_req_valid), .acc_req_ready(acc_req_ready),
    .acc_req_op(acc_req_op), .acc_req_addr(acc_req_addr), .acc_req_data(acc_req_data),
    .acc_rsp_valid(acc_rsp_valid), .acc_rsp_data(acc_rsp_data), .acc_rsp_err(acc_rsp_err)
  );

  always #5 clk_clk = ~clk_clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   issues   = 0;
  logic prev_valid = 1'b0;

  // Software-visible model state
  logic        req_bit, exp_ack, exp_err, exp_tmo;
  int          exp_count;
  logic [7:0]  exp_last_op;
  logic [31:0] exp_result, exp_elapsed;

  always @(posedge clk_clk) begin
    prev_valid <= acc_req_valid;
    if (acc_req_valid && !prev_valid) issues <= issues + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_stat(input int cnt, input logic [7:0] op,
                                           input logic tmo, input logic err,
                                           input logic busy, input logic ack);
    logic [15:0] c16;
    c16 = cnt[15:0];
    return {c16, op, 4'h0, tmo, err, busy, ack};
  endfunction

  // a: ISSUE cycle (1-based) in which ready is given; b: cycle of the response.
  // The model: response by cycle L completes with elapsed=b, otherwise timeout at L.
  task automatic run_cmd(input logic [7:0] op, input logic [ADDR_W-1:0] addr,
                         input logic [31:0] data, input int a, input int b,
                         input logic [31:0] rdata, input logic rerr,
                         input logic [15:0] lim, input bit dbl);
    int L, c;
    bit to;
    L  = (lim == 16'h0) ? 65535 : int'(lim);
    to = (b > L);
    c  = to ? L : b;
    pio_out0 = {{(24-ADDR_W){1'b0}}, addr, op};
    pio_out1 = data;
    pio_out3 = {16'h0000, lim};
    req_bit  = ~req_bit;
    pio_out2 = {1'b0, 30'h0, req_bit};
    for (int k = 1; k <= c; k++) begin
      @(negedge clk_clk);
      chk("req_valid", {31'h0, acc_req_valid}, {31'h0, (k <= a)});
      if (k == 1) begin
        chk("req_op", {24'h0, acc_req_op}, {24'h0, op});
        chk("req_addr", {24'h0, acc_req_addr}, {24'h0, addr});
        chk("req_data", acc_req_data, data);
        chk("busy_set", {31'h0, pio_in1[1]}, 32'h1);
      end
      acc_req_ready = (k == a);
      acc_rsp_valid = (k == b);
      acc_rsp_data  = (k == b) ? rdata : $urandom;
      acc_rsp_err   = (k == b) ? rerr : 1'($urandom_range(0, 1));
      if (dbl && (k == 2 || k == 3)) begin
        req_bit  = ~req_bit;
        pio_out2 = {1'b0, 30'h0, req_bit};
      end
    end
    @(negedge clk_clk);
    acc_req_ready = 1'b0;
    acc_rsp_valid = 1'b0;
    acc_rsp_err   = 1'b0;
    chk("valid_done", {31'h0, acc_req_valid}, 32'h0);
    chk("ack_pre", {30'h0, pio_in1[1:0]}, {30'h0, 1'b1, exp_ack});
    @(negedge clk_clk);
    exp_ack     = ~exp_ack;
    exp_count   = exp_count + 1;
    exp_last_op = op;
    exp_tmo     = to;
    exp_err     = to ? 1'b0 : rerr;
    exp_result  = to ? 32'h0 : rdata;
    exp_elapsed = c;
    chk("result", pio_in0, exp_result);
    chk("status", pio_in1, exp_stat(exp_count, exp_last_op, exp_tmo, exp_err, 1'b0, exp_ack));
    chk("elapsed", pio_in2, exp_elapsed);
  endtask

  initial begin
    int i0, n, a, b;
    logic [15:0] lim;
    logic [31:0] d;

    reset_reset_n = 1'b0;
    pio_out0 = '0; pio_out1 = '0; pio_out2 = '0; pio_out3 = '0;
    acc_req_ready = 1'b0; acc_rsp_valid = 1'b0; acc_rsp_data = '0; acc_rsp_err = 1'b0;
    req_bit = 1'b0; exp_ack = 1'b0; exp_count = 0; exp_last_op = '0;
    exp_err = 1'b0; exp_tmo = 1'b0; exp_result = '0; exp_elapsed = '0;
    repeat (3) @(negedge clk_clk);
    reset_reset_n = 1'b1;
    @(negedge clk_clk);
    chk("rst_status", pio_in1, 32'h0);
    chk("rst_version", pio_in3, VERSION);
    chk("rst_result", pio_in0, 32'h0);
    chk("rst_elapsed", pio_in2, 32'h0);
    chk("rst_valid", {31'h0, acc_req_valid}, 32'h0);

    // Basic command: ready in cycle 3, response 4 cycles later
    run_cmd(8'h05, 8'h3C, 32'h1234_5678, 3, 7, 32'hCAFE_F00D, 1'b0, 16'h0, 1'b0);
    // Error response
    run_cmd(8'h11, 8'h02, 32'hDEAD_0001, 1, 2, 32'h0BAD_0BAD, 1'b1, 16'h0, 1'b0);
    // Timeout with no response, then a late response while idle
    run_cmd(8'h22, 8'h7F, 32'h0000_00AA, 2, NEVER, 32'h0, 1'b0, 16'd10, 1'b0);
    @(negedge clk_clk);
    acc_rsp_valid = 1'b1; acc_rsp_data = 32'hFFFF_FFFF; acc_rsp_err = 1'b1;
    @(negedge clk_clk);
    acc_rsp_valid = 1'b0; acc_rsp_err = 1'b0;
    @(negedge clk_clk);
    chk("late_result", pio_in0, 32'h0);
    chk("late_status", pio_in1, exp_stat(exp_count, exp_last_op, 1'b1, 1'b0, 1'b0, exp_ack));
    chk("late_valid", {31'h0, acc_req_valid}, 32'h0);

    for (int i = 0; i < 20; i++) begin
      a   = $urandom_range(1, 6);
      b   = a + $urandom_range(0, 8);
      lim = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom_range(3, 12));
      run_cmd(8'($urandom), 8'($urandom), $urandom, a, b, $urandom,
              1'($urandom_range(0, 1)), lim, 1'b0);
    end

    // Double toggle while busy issues exactly one command
    i0 = issues;
    run_cmd(8'h33, 8'h44, 32'h5555_AAAA, 1, 6, 32'h1357_9BDF, 1'b0, 16'h0, 1'b1);
    repeat (8) @(negedge clk_clk);
    chk("dbl_issues", issues - i0, 32'd1);

    // Soft clear in WAIT_RSP
    pio_out0 = 32'h0000_0942;
    pio_out3 = 32'h0;
    req_bit  = ~req_bit;
    pio_out2 = {1'b0, 30'h0, req_bit};
    @(negedge clk_clk); acc_req_ready = 1'b1;
    @(negedge clk_clk); acc_req_ready = 1'b0;
    @(negedge clk_clk);
    i0 = issues;
    pio_out2 = {1'b1, 30'h0, req_bit};
    @(negedge clk_clk);
    exp_ack = req_bit; exp_count = 0;
    chk("clr_valid", {31'h0, acc_req_valid}, 32'h0);
    chk("clr_status", pio_in1, exp_stat(0, exp_last_op, 1'b0, 1'b0, 1'b0, exp_ack));
    chk("clr_result", pio_in0, 32'h0);
    chk("clr_elapsed", pio_in2, 32'h0);
    pio_out2 = {1'b0, 30'h0, req_bit};
    repeat (6) @(negedge clk_clk);
    chk("clr_issues", issues - i0, 32'd0);
    chk("clr_status2", pio_in1, exp_stat(0, exp_last_op, 1'b0, 1'b0, 1'b0, exp_ack));

    // Back-to-back with ready and response tied high
    pio_out0 = 32'h0000_0177;
    acc_req_ready = 1'b1; acc_rsp_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      d = $urandom;
      acc_rsp_data = d;
      req_bit  = ~req_bit;
      pio_out2 = {1'b0, 30'h0, req_bit};
      n = 0;
      do begin
        @(negedge clk_clk);
        n++;
      end while (pio_in1[0] != req_bit && n < 10);
      chk("b2b_cycles", n, 32'd3);
      chk("b2b_elapsed", pio_in2, 32'd1);
      chk("b2b_result", pio_in0, d);
    end
    exp_count = 100; exp_ack = req_bit; exp_last_op = 8'h77;
    chk("b2b_status", pio_in1, exp_stat(exp_count, exp_last_op, 1'b0, 1'b0, 1'b0, exp_ack));
    acc_req_ready = 1'b0; acc_rsp_valid = 1'b0;
    @(negedge clk_clk);

    // Reset in the middle of ISSUE
    req_bit  = ~req_bit;
    pio_out2 = {1'b0, 30'h0, req_bit};
    @(negedge clk_clk);
    chk("mid_valid", {31'h0, acc_req_valid}, 32'h1);
    @(negedge clk_clk);
    reset_reset_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'h0, acc_req_valid}, 32'h0);
    req_bit = 1'b0; pio_out2 = '0;
    repeat (2) @(negedge clk_clk);
    reset_reset_n = 1'b1;
    @(negedge clk_clk);
    chk("rst2_status", pio_in1, 32'h0);
    chk("rst2_version", pio_in3, VERSION);
    repeat (4) @(negedge clk_clk);
    chk("rst2_valid", {31'h0, acc_req_valid}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
